lvds_capture_ctrl: RTL and testbench
====================================

// Module: lvds_capture_ctrl
// PURPOSE
//  Capture sequencer for the A1100 LVDS receive path, in the 100 MHz clk domain.
//  Powers up the sensor by releasing XSHUTDOWN (RST_A), then RSTN (RST_D).
//  Opens fixed-length capture windows (cap_en) that gate the receiver's FIFO writes.
//  Defers a window when the FIFO is near full, and counts frames to a programmed total.
// PARAMETERS
//  CNT_W     16    width of num_frames / frame_cnt / drop_cnt
//  T_RST     1000  cycles both sensor resets held low after start (10 us)
//  T_A2D     500   cycles from RST_A release to RST_D release
//  T_SETTLE  2000  cycles after RST_D release before first window
//  WIN_LEN   513   cycles cap_en held high per window (512 valid words + 1)
//  GAP_LEN   64    idle cycles between windows (min 1)
// PORTS
//  clk             in   1      system clock, 100 MHz
//  rst             in   1      synchronous reset, active-high
//  start           in   1      1-cycle request to begin a capture run
//  stop            in   1      1-cycle request to end the run
//  num_frames      in   CNT_W  windows per run; 0 = continuous; sampled on accepted start
//  fifo_prog_full  in   1      FIFO programmable-full, already synchronised to clk
//  fifo_overflow   in   1      FIFO overflow flag, already synchronised to clk
//  RST_A           out  1      sensor analog reset (XSHUTDOWN), active-low
//  RST_D           out  1      sensor digital reset (RSTN), active-low
//  cap_en          out  1      capture window; FIFO write enable gate
//  frame_start     out  1      1-cycle pulse on the first cap_en cycle of each window
//  busy            out  1      high in every state except IDLE and DONE
//  done            out  1      high while in DONE
//  frame_cnt       out  CNT_W  windows completed this run
//  overflow_stky   out  1      sticky fifo_overflow; cleared on accepted start
//  drop_cnt        out  CNT_W  windows skipped due to prog_full (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0 (sensor held in reset); state IDLE; all counters 0.
//  FSM states: IDLE, RST_HOLD, A_REL, D_SETTLE, ARMED, CAPTURE, GAP, DONE.
//   One shared down-counter times each state.
//  IDLE: RST_A=RST_D=0.
//   start (and no stop) -> RST_HOLD next cycle.
//   On that transition: latch num_frames, clear frame_cnt, drop_cnt, overflow_stky.
//  RST_HOLD: T_RST cycles, RST_A=RST_D=0 -> A_REL.
//  A_REL: T_A2D cycles, RST_A=1, RST_D=0 -> D_SETTLE.
//  D_SETTLE: T_SETTLE cycles, RST_A=RST_D=1 -> ARMED.
//  ARMED: a single cycle. Decides between a capture and a skip:
//   fifo_prog_full=0 -> CAPTURE.
//   fifo_prog_full=1 -> GAP with no capture; drop_cnt+1.
//  CAPTURE: cap_en=1 for exactly WIN_LEN cycles; frame_start=1 on the first of them.
//   Leaving CAPTURE: frame_cnt+1, then exit checks in priority order:
//   1) num_frames!=0 and new frame_cnt==num_frames -> DONE
//   2) stop_pend -> IDLE
//   3) otherwise -> GAP
//  GAP: GAP_LEN cycles -> ARMED.
//  DONE: RST_A=RST_D=1 (sensor stays up); done=1.
//   start -> ARMED, skipping power-up; same latch/clear as from IDLE.
//   stop -> IDLE.
//  stop rules:
//   In RST_HOLD, A_REL, D_SETTLE, ARMED, GAP: IDLE next cycle; resets drop to 0 same edge.
//   In CAPTURE: sets stop_pend; the window completes its full WIN_LEN, then IDLE.
//   The final window is counted in frame_cnt.
//  start while busy is ignored. start+stop in the same cycle: stop wins.
//  Continuous mode (num_frames=0): frame_cnt wraps at 2^CNT_W and never enters DONE.
//  drop_cnt saturates at all-ones.
//  overflow_stky sets on any fifo_overflow=1 cycle in any state; sticky until next start.
//  rst mid-operation: next edge returns to reset values.
//   cap_en drops immediately, even mid-window.
//  All outputs are registered; no combinational input-to-output path.
// CONFIGURATION
//  LVDS_CTRL_DROP_CNT_EN defined:
//   drop_cnt counts skipped windows as above.
//  LVDS_CTRL_DROP_CNT_EN undefined:
//   drop_cnt tied to 0; counter logic removed.
//   ARMED with prog_full=1 stalls in ARMED until prog_full=0, then CAPTURE.
//   No window is skipped; frame timing stretches instead.
// TESTING  (T_RST=4 T_A2D=3 T_SETTLE=5 WIN_LEN=8 GAP_LEN=2 CNT_W=8)
//  1) start@c0, num_frames=2:
//     RST_A rises c5, RST_D rises c8, cap_en c14-21 and c25-32.
//     frame_start pulses c14 and c25; done=1 from c33; frame_cnt=2.
//  2) Continuous run with stop at 3rd cycle of a window:
//     cap_en stays high the full 8 cycles, then IDLE.
//     RST_A=RST_D=0 the next cycle; frame_cnt incremented.
//  3) prog_full=1 at ARMED, macro defined:
//     no cap_en that slot; drop_cnt=1; next window after GAP.
//     Same case with macro undefined: stalls in ARMED; cap_en starts 1 cycle after prog_full=0.
//  4) stop during A_REL: IDLE next cycle, RST_A=0, busy=0.
//     start and stop in the same cycle from IDLE: stays IDLE.
//  5) fifo_overflow 1-cycle pulse mid-run: overflow_stky=1 and held through DONE.
//     Restart from DONE: cleared, first cap_en 2 cycles after start (no power-up).
//  6) rst pulse mid-CAPTURE: next cycle cap_en=0, RST_A=RST_D=0, frame_cnt=0, busy=0.

Source files
------------

// File: rtl/lvds_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lvds_capture_ctrl
// Purpose  : Capture sequencer for the A1100 LVDS receive path. Powers the
//            sensor up (RST_A, then RST_D), opens fixed-length capture windows
//            that gate FIFO writes, defers windows on FIFO near-full and
//            counts frames up to a programmed total.
// Options  : LVDS_CTRL_DROP_CNT_EN - when defined, a near-full FIFO at ARMED
//            skips that window and counts it in drop_cnt; when undefined the
//            sequencer waits in ARMED instead and drop_cnt reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module lvds_capture_ctrl #(
  parameter int CNT_W    = 16,
  parameter int T_RST    = 1000,
  parameter int T_A2D    = 500,
  parameter int T_SETTLE = 2000,
  parameter int WIN_LEN  = 513,
  parameter int GAP_LEN  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_frames,
  input  logic             fifo_prog_full,
  input  logic             fifo_overflow,
  output logic             RST_A,
  output logic             RST_D,
  output logic             cap_en,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overflow_stky,
  output logic [CNT_W-1:0] drop_cnt
);

  // Shared timer must hold the longest state duration minus one.
  localparam int MAX_1 = (T_RST > T_A2D) ? T_RST : T_A2D;
  localparam int MAX_2 = (MAX_1 > T_SETTLE) ? MAX_1 : T_SETTLE;
  localparam int MAX_3 = (MAX_2 > WIN_LEN) ? MAX_2 : WIN_LEN;
  localparam int MAX_T = (MAX_3 > GAP_LEN) ? MAX_3 : GAP_LEN;
  localparam int TMR_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    A_REL    = 3'd2,
    D_SETTLE = 3'd3,
    ARMED    = 3'd4,
    CAPTURE  = 3'd5,
    GAP      = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_load;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] cnt_inc;
  logic             stop_pend;
  logic             tmr_zero;
  logic             last_frame;
  logic             start_ok;

  // Next-state decision; stop aborts everywhere except mid-window.
  always_comb begin
    cnt_inc    = frame_cnt + CNT_ONE;
    tmr_zero   = (tmr == '0);
    last_frame = (num_lat != '0) && (cnt_inc == num_lat);
    nxt        = state;
    case (state)
      IDLE:     if (start && !stop) nxt = RST_HOLD;
      RST_HOLD: if (stop) nxt = IDLE; else if (tmr_zero) nxt = A_REL;
      A_REL:    if (stop) nxt = IDLE; else if (tmr_zero) nxt = D_SETTLE;
      D_SETTLE: if (stop) nxt = IDLE; else if (tmr_zero) nxt = ARMED;
      ARMED: begin
        if (stop)                 nxt = IDLE;
        else if (!fifo_prog_full) nxt = CAPTURE;
`ifdef LVDS_CTRL_DROP_CNT_EN
        else                      nxt = GAP;
`endif
      end
      CAPTURE: begin
        if (tmr_zero) begin
          if (last_frame)             nxt = DONE;
          else if (stop_pend || stop) nxt = IDLE;
          else                        nxt = GAP;
        end
      end
      GAP:      if (stop) nxt = IDLE; else if (tmr_zero) nxt = ARMED;
      DONE:     if (stop) nxt = IDLE; else if (start) nxt = ARMED;
      default:  nxt = IDLE;
    endcase
    start_ok = ((state == IDLE) && (nxt == RST_HOLD)) ||
               ((state == DONE) && (nxt == ARMED));
  end

  // Timer reload value: duration of the state being entered, minus one.
  always_comb begin
    tmr_load = '0;
    case (nxt)
      RST_HOLD: tmr_load = TMR_W'(T_RST - 1);
      A_REL:    tmr_load = TMR_W'(T_A2D - 1);
      D_SETTLE: tmr_load = TMR_W'(T_SETTLE - 1);
      CAPTURE:  tmr_load = TMR_W'(WIN_LEN - 1);
      GAP:      tmr_load = TMR_W'(GAP_LEN - 1);
      default:  tmr_load = '0;
    endcase
  end

  // State, timer, counters and outputs decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmr           <= '0;
      RST_A         <= 1'b0;
      RST_D         <= 1'b0;
      cap_en        <= 1'b0;
      frame_start   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      num_lat       <= '0;
      frame_cnt     <= '0;
      overflow_stky <= 1'b0;
      stop_pend     <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)  tmr <= tmr_load;
      else if (!tmr_zero) tmr <= tmr - TMR_ONE;
      RST_A       <= (nxt != IDLE) && (nxt != RST_HOLD);
      RST_D       <= (nxt != IDLE) && (nxt != RST_HOLD) && (nxt != A_REL);
      cap_en      <= (nxt == CAPTURE);
      frame_start <= (nxt == CAPTURE) && (state != CAPTURE);
      busy        <= (nxt != IDLE) && (nxt != DONE);
      done        <= (nxt == DONE);
      if (start_ok) begin
        num_lat   <= num_frames;
        frame_cnt <= '0;
      end else if ((state == CAPTURE) && tmr_zero) begin
        frame_cnt <= cnt_inc;
      end
      // A same-cycle overflow wins over the clear on start.
      overflow_stky <= fifo_overflow | (overflow_stky & ~start_ok);
      // A stop seen mid-window is remembered until the window closes.
      stop_pend <= (state == CAPTURE) && (nxt == CAPTURE) && (stop_pend || stop);
    end
  end

`ifdef LVDS_CTRL_DROP_CNT_EN
  logic [CNT_W-1:0] drop_q;

  // Saturating count of windows skipped because the FIFO was near full.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      drop_q <= '0;
    end else if ((state == ARMED) && (nxt == GAP) && (drop_q != '1)) begin
      drop_q <= drop_q + CNT_ONE;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lvds_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvds_capture_ctrl
// Purpose  : Directed self-checking bench for lvds_capture_ctrl with short
//            timing parameters; expected values are hand-derived cycle numbers.
//            Cycle c is the clock period in which inputs set at the negedge of
//            c are sampled by the following posedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lvds_capture_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] num_frames;
  logic       fifo_prog_full;
  logic       fifo_overflow;
  logic       RST_A;
  logic       RST_D;
  logic       cap_en;
  logic       frame_start;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;
  logic       overflow_stky;
  logic [7:0] drop_cnt;

  int n_checks;
  int n_fail;

  lvds_capture_ctrl #(
    .CNT_W(8), .T_RST(4), .T_A2D(3), .T_SETTLE(5), .WIN_LEN(8), .GAP_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_frames(num_frames),
    .fifo_prog_full(fifo_prog_full), .fifo_overflow(fifo_overflow),
    .RST_A(RST_A), .RST_D(RST_D), .cap_en(cap_en), .frame_start(frame_start),
    .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .overflow_stky(overflow_stky), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: RST_A, RST_D, cap_en, frame_start, busy, done.
  function automatic logic [5:0] outs();
    return {RST_A, RST_D, cap_en, frame_start, busy, done};
  endfunction

  task automatic apply_reset();
    start = 1'b0; stop = 1'b0; num_frames = '0;
    fifo_prog_full = 1'b0; fifo_overflow = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    start = 1'b0; stop = 1'b0; num_frames = 8'd5;
    fifo_prog_full = 1'b0; fifo_overflow = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({outs(), frame_cnt, overflow_stky, drop_cnt} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_values: got outs=%b fc=%0d ov=%b drop=%0d required all 0",
               outs(), frame_cnt, overflow_stky, drop_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({outs(), frame_cnt} !== 14'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got outs=%b fc=%0d required 0", outs(), frame_cnt);
    end
  endtask

  task automatic test_two_frames();
    logic [5:0] e;
    logic [7:0] efc;
    apply_reset();
    for (int c = 0; c <= 36; c++) begin
      e = {c >= 5, c >= 8, (c >= 14 && c <= 21) || (c >= 25 && c <= 32),
           c == 14 || c == 25, c >= 1 && c <= 32, c >= 33};
      efc = (c >= 33) ? 8'd2 : (c >= 22) ? 8'd1 : 8'd0;
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL two_frames outs c%0d: got %b required %b", c, outs(), e);
      end
      n_checks++;
      if (frame_cnt !== efc) begin
        n_fail++;
        $display("FAIL two_frames frame_cnt c%0d: got %0d required %0d", c, frame_cnt, efc);
      end
      // The second start lands mid-window and must be ignored.
      start = (c == 0) || (c == 20);
      num_frames = 8'd2;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_continuous_stop();
    logic [5:0] e;
    logic [7:0] efc;
    int k;
    apply_reset();
    for (int c = 0; c <= 2840; c++) begin
      e = {c >= 5 && c <= 2837, c >= 8 && c <= 2837,
           c >= 14 && ((c - 14) % 11) < 8,
           c >= 14 && ((c - 14) % 11) == 0,
           c >= 1 && c <= 2837, 1'b0};
      k = (c >= 22) ? ((c - 22) / 11 + 1) : 0;
      efc = 8'(k);
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL continuous outs c%0d: got %b required %b", c, outs(), e);
      end
      n_checks++;
      if (frame_cnt !== efc) begin
        n_fail++;
        $display("FAIL continuous frame_cnt c%0d: got %0d required %0d", c, frame_cnt, efc);
      end
      start = (c == 0);
      stop = (c == 2832);
      num_frames = 8'd0;
      @(negedge clk);
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_prog_full();
    logic ecap;
    logic [7:0] edrop;
    apply_reset();
    for (int c = 0; c <= 32; c++) begin
`ifdef LVDS_CTRL_DROP_CNT_EN
      ecap  = (c >= 20 && c <= 27) || (c >= 31 && c <= 38);
      edrop = (c >= 17) ? 8'd2 : (c >= 14) ? 8'd1 : 8'd0;
`else
      ecap  = (c >= 18 && c <= 25) || (c >= 29 && c <= 36);
      edrop = 8'd0;
`endif
      n_checks++;
      if (cap_en !== ecap) begin
        n_fail++;
        $display("FAIL prog_full cap_en c%0d: got %b required %b", c, cap_en, ecap);
      end
      n_checks++;
      if (drop_cnt !== edrop) begin
        n_fail++;
        $display("FAIL prog_full drop_cnt c%0d: got %0d required %0d", c, drop_cnt, edrop);
      end
      start = (c == 0);
      num_frames = 8'd0;
      fifo_prog_full = (c >= 13 && c <= 16);
      @(negedge clk);
    end
    start = 1'b0;
    fifo_prog_full = 1'b0;
  endtask

  task automatic test_stop_early();
    logic [5:0] e;
    apply_reset();
    for (int c = 0; c <= 13; c++) begin
      e = {c == 5 || c == 6, 1'b0, 1'b0, 1'b0, c >= 1 && c <= 6, 1'b0};
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL stop_early outs c%0d: got %b required %b", c, outs(), e);
      end
      start = (c == 0) || (c == 10);
      stop = (c == 6) || (c == 10);
      num_frames = 8'd3;
      @(negedge clk);
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_overflow_restart();
    logic [5:0] e;
    logic [7:0] efc;
    logic       eov;
    apply_reset();
    for (int c = 0; c <= 48; c++) begin
      e = {c >= 5, c >= 8,
           (c >= 14 && c <= 21) || (c >= 28 && c <= 35) || (c >= 39 && c <= 46),
           c == 14 || c == 28 || c == 39,
           (c >= 1 && c <= 21) || (c >= 27 && c <= 46),
           (c >= 22 && c <= 26) || c >= 47};
      efc = (c >= 47) ? 8'd2 : (c >= 36) ? 8'd1 : (c >= 27) ? 8'd0 :
            (c >= 22) ? 8'd1 : 8'd0;
      eov = (c >= 11 && c <= 26);
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL overflow_restart outs c%0d: got %b required %b", c, outs(), e);
      end
      n_checks++;
      if (frame_cnt !== efc) begin
        n_fail++;
        $display("FAIL overflow_restart frame_cnt c%0d: got %0d required %0d", c, frame_cnt, efc);
      end
      n_checks++;
      if (overflow_stky !== eov) begin
        n_fail++;
        $display("FAIL overflow_restart overflow_stky c%0d: got %b required %b", c, overflow_stky, eov);
      end
      start = (c == 0) || (c == 26);
      num_frames = (c < 26) ? 8'd1 : 8'd2;
      fifo_overflow = (c == 10);
      @(negedge clk);
    end
    start = 1'b0;
    fifo_overflow = 1'b0;
  endtask

  task automatic test_rst_mid_capture();
    logic [5:0] e;
    logic [7:0] efc;
    apply_reset();
    for (int c = 0; c <= 30; c++) begin
      if (c <= 27) begin
        e = {c >= 5, c >= 8, (c >= 14 && c <= 21) || (c >= 25 && c <= 27),
             c == 14 || c == 25, c >= 1, 1'b0};
        efc = (c >= 22) ? 8'd1 : 8'd0;
      end else begin
        e = 6'd0;
        efc = 8'd0;
      end
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL rst_mid_capture outs c%0d: got %b required %b", c, outs(), e);
      end
      n_checks++;
      if (frame_cnt !== efc) begin
        n_fail++;
        $display("FAIL rst_mid_capture frame_cnt c%0d: got %0d required %0d", c, frame_cnt, efc);
      end
      start = (c == 0);
      num_frames = 8'd0;
      rst = (c == 27);
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    num_frames = '0;
    fifo_prog_full = 1'b0;
    fifo_overflow = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_frames();
    test_continuous_stop();
    test_prog_full();
    test_stop_early();
    test_overflow_restart();
    test_rst_mid_capture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
